mem_access_ctrl: RTL and testbench

Memory-stage access controller for the pipelined core. It sits between the EX/MEM latch and the MEM/WB latch, and owns the data-cache request handshake. It holds the pipeline (memW low) while a load, store, LL or SC is outstanding, and presents load or SC-result data to the MEM/WB latch. It also maintains the LL/SC link register, including snoop invalidation.

---
 rtl/cpu_types_pkg.sv | 14 +
 rtl/mem_access_ctrl_if.sv | 43 ++++
 rtl/mem_access_ctrl_link_reg.sv | 42 ++++
 rtl/mem_access_ctrl.sv | 102 ++++++++++
 tb/tb_mem_access_ctrl.sv | 253 +++++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_types_pkg.sv
// Shared types for the memory stage: data word and access-controller FSM states.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } mem_state_t;

endpackage

// File: rtl/mem_access_ctrl_if.sv
// Bundle between EX/MEM latch, data cache, coherence snoop and MEM/WB latch.
// Latency: n/a (wires only).
// Backpressure: memW low holds the EX/MEM and MEM/WB latches.
// master: the access controller; slave: the pipeline/cache/coherence side.
interface mem_access_ctrl_if;
    import cpu_types_pkg::*;

    // EX/MEM side
    logic  memREN;
    logic  memDWEN;
    logic  memLL;
    logic  memSC;
    logic  memcuHALT;
    word_t memaddr;
    word_t memstore;
    // data cache side
    logic  dhit;
    word_t dmemload;
    logic  dmemREN;
    logic  dmemWEN;
    logic  datomic;
    word_t dmemaddr;
    word_t dmemstore;
    // coherence snoop
    logic  ccinv;
    word_t ccsnoopaddr;
    // MEM/WB side
    logic  memW;
    word_t memdmemload;

    modport master (
        input  memREN, memDWEN, memLL, memSC, memcuHALT, memaddr, memstore,
        input  dhit, dmemload, ccinv, ccsnoopaddr,
        output dmemREN, dmemWEN, datomic, dmemaddr, dmemstore, memW, memdmemload
    );

    modport slave (
        output memREN, memDWEN, memLL, memSC, memcuHALT, memaddr, memstore,
        output dhit, dmemload, ccinv, ccsnoopaddr,
        input  dmemREN, dmemWEN, datomic, dmemaddr, dmemstore, memW, memdmemload
    );

endinterface

// File: rtl/mem_access_ctrl_link_reg.sv
// LL/SC link register: set by LL completion, cleared by SC or a matching snoop.
// Latency: state updates on the next CLK edge; match is combinational.
// Backpressure: none; set has priority over clear and snoop in the same cycle.
// Ports: set/set_addr, clear, snoop_inv/snoop_addr, query_addr -> match.
module mem_access_ctrl_link_reg
    import cpu_types_pkg::*;
(
    input  logic  CLK,
    input  logic  nRST,
    input  logic  set,
    input  word_t set_addr,
    input  logic  clear,
    input  logic  snoop_inv,
    input  word_t snoop_addr,
    input  word_t query_addr,
    output logic  match
);

    logic  link_valid;
    word_t link_addr;
    logic  snoop_hit;
    logic  unused_bits;

    // Linking is per word; byte offset bits never take part in a compare.
    assign snoop_hit   = snoop_inv && link_valid && (snoop_addr[31:2] == link_addr[31:2]);
    assign match       = link_valid && (query_addr[31:2] == link_addr[31:2]);
    assign unused_bits = ^{snoop_addr[1:0], query_addr[1:0]};

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            link_valid <= 1'b0;
            link_addr  <= '0;
        end else if (set) begin
            // An LL finishing in the same cycle as a snoop keeps its link.
            link_valid <= 1'b1;
            link_addr  <= set_addr;
        end else if (clear || snoop_hit) begin
            link_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/mem_access_ctrl.sv
// Memory-stage access controller: drives the D-cache handshake, stalls the pipe, owns LL/SC link.
// Latency: cache hit in first WAIT cycle -> 2 stall cycles; failing SC -> 1 stall cycle.
// Backpressure: memW low while an access is outstanding; waits indefinitely on dhit.
// Ports: CLK, nRST (async, active-low); bus (master) carries EX/MEM, cache, snoop and MEM/WB signals.
module mem_access_ctrl
    import cpu_types_pkg::*;
(
    input  logic               CLK,
    input  logic               nRST,
    mem_access_ctrl_if.master  bus
);

    mem_state_t state;
    mem_state_t next_state;
    word_t      data_reg;
    logic       mem_op;
    logic       sc_ok;
    logic       link_set;
    logic       link_clear;

    assign mem_op = (bus.memREN || bus.memDWEN || bus.memLL || bus.memSC) && !bus.memcuHALT;

    // Any SC seen in IDLE consumes the link, whether it succeeds or not.
    assign link_clear = (state == IDLE) && mem_op && bus.memSC;
    assign link_set   = (state == WAIT) && bus.dhit && bus.memLL;

    mem_access_ctrl_link_reg link_reg (
        .CLK        (CLK),
        .nRST       (nRST),
        .set        (link_set),
        .set_addr   (bus.memaddr),
        .clear      (link_clear),
        .snoop_inv  (bus.ccinv),
        .snoop_addr (bus.ccsnoopaddr),
        .query_addr (bus.memaddr),
        .match      (sc_ok)
    );

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (mem_op) begin
                    // A failing SC never touches the cache.
                    next_state = (bus.memSC && !sc_ok) ? DONE : WAIT;
                end
            end
            WAIT: begin
                if (bus.dhit) begin
                    next_state = DONE;
                end
            end
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        bus.dmemREN = 1'b0;
        bus.dmemWEN = 1'b0;
        bus.datomic = 1'b0;
        bus.memW    = 1'b0;
        case (state)
            IDLE: bus.memW = !mem_op;
            WAIT: begin
                bus.dmemREN = bus.memREN || bus.memLL;
                bus.dmemWEN = bus.memDWEN || bus.memSC;
                bus.datomic = bus.memLL || bus.memSC;
            end
            DONE:    bus.memW = 1'b1;
            default: bus.memW = 1'b0;
        endcase
    end

    // Result register: load data, or the SC outcome flag; plain stores leave it alone.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            data_reg <= '0;
        end else if ((state == IDLE) && mem_op && bus.memSC && !sc_ok) begin
            data_reg <= '0;
        end else if ((state == WAIT) && bus.dhit) begin
            if (bus.memSC) begin
                data_reg <= 32'd1;
            end else if (bus.memREN || bus.memLL) begin
                data_reg <= bus.dmemload;
            end
        end
    end

    assign bus.dmemaddr    = bus.memaddr;
    assign bus.dmemstore   = bus.memstore;
    assign bus.memdmemload = data_reg;

endmodule

// File: tb/tb_mem_access_ctrl.sv
module tb_mem_access_ctrl;
    import cpu_types_pkg::*;

    typedef enum int {K_LW, K_SW, K_LL, K_SC} kind_t;

    logic CLK = 1'b0;
    logic nRST;
    always #5 CLK = ~CLK;

    mem_access_ctrl_if bus ();

    mem_access_ctrl dut (
        .CLK  (CLK),
        .nRST (nRST),
        .bus  (bus)
    );

    int n_pass  = 0;
    int n_total = 0;
    logic chk_en = 1'b0;

    // per-cycle expectations
    logic  exp_memW, exp_ren, exp_wen, exp_atomic, exp_load_vld;
    word_t exp_addr, exp_store, exp_load;

    // transaction-level model of the architectural state
    logic  m_valid = 1'b0;
    word_t m_addr  = '0;
    word_t m_data  = '0;

    int    stall_cnt  = 0;
    int    last_stall = 0;
    word_t last_load  = '0;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
    endtask

    always @(negedge CLK) begin
        if (chk_en) begin
            check1("memW", bus.memW, exp_memW);
            check1("dmemREN", bus.dmemREN, exp_ren);
            check1("dmemWEN", bus.dmemWEN, exp_wen);
            check1("datomic", bus.datomic, exp_atomic);
            check32("dmemaddr", bus.dmemaddr, exp_addr);
            check32("dmemstore", bus.dmemstore, exp_store);
            if (exp_load_vld) begin
                check32("memdmemload", bus.memdmemload, exp_load);
                last_load = bus.memdmemload;
            end
            if (!bus.memW) stall_cnt++;
            else begin
                if (stall_cnt != 0) last_stall = stall_cnt;
                stall_cnt = 0;
            end
        end
    end

    function automatic logic same_word(input word_t a, input word_t b);
        return a[31:2] == b[31:2];
    endfunction

    task automatic next_cycle();
        @(posedge CLK);
        #1;
    endtask

    task automatic clear_inputs();
        bus.memREN = 0; bus.memDWEN = 0; bus.memLL = 0; bus.memSC = 0; bus.memcuHALT = 0;
        bus.memaddr = '0; bus.memstore = '0; bus.dhit = 0; bus.dmemload = '0;
        bus.ccinv = 0; bus.ccsnoopaddr = '0;
    endtask

    task automatic exp_quiet(input logic memw, input word_t addr, input word_t sdata);
        exp_memW = memw; exp_ren = 0; exp_wen = 0; exp_atomic = 0; exp_load_vld = 0;
        exp_addr = addr; exp_store = sdata;
    endtask

    task automatic set_op(input kind_t k, input word_t addr, input word_t sdata);
        bus.memREN  = (k == K_LW);
        bus.memDWEN = (k == K_SW);
        bus.memLL   = (k == K_LL);
        bus.memSC   = (k == K_SC);
        bus.memcuHALT = 0;
        bus.memaddr = addr;
        bus.memstore = sdata;
    endtask

    task automatic idle(input int n, input logic spur_hit, input logic snoop, input word_t saddr);
        for (int i = 0; i < n; i++) begin
            next_cycle();
            clear_inputs();
            bus.dhit = spur_hit; bus.dmemload = 32'hBAD0BAD0;
            bus.ccinv = snoop; bus.ccsnoopaddr = saddr;
            exp_quiet(1'b1, '0, '0);
            if (snoop && m_valid && same_word(saddr, m_addr)) m_valid = 0;
        end
    endtask

    // One EX/MEM instruction from IDLE detection through DONE.
    task automatic run_op(input kind_t k, input word_t addr, input word_t sdata, input int hit_at,
                          input word_t ldata, input int snoop_at, input word_t saddr,
                          input logic early_hit);
        logic sc_fail;
        logic snoop_hit;
        next_cycle();
        clear_inputs();
        set_op(k, addr, sdata);
        bus.dhit = early_hit; bus.dmemload = ~ldata;
        exp_quiet(1'b0, addr, sdata);
        sc_fail = (k == K_SC) && !(m_valid && same_word(m_addr, addr));
        if (k == K_SC) m_valid = 0;
        if (sc_fail) m_data = '0;
        else begin
            for (int w = 1; w <= hit_at; w++) begin
                next_cycle();
                bus.dhit = (w == hit_at);
                bus.dmemload = (w == hit_at) ? ldata : 32'h0;
                bus.ccinv = (w == snoop_at); bus.ccsnoopaddr = saddr;
                exp_quiet(1'b0, addr, sdata);
                exp_ren    = (k == K_LW) || (k == K_LL);
                exp_wen    = (k == K_SW) || (k == K_SC);
                exp_atomic = (k == K_LL) || (k == K_SC);
                snoop_hit = (w == snoop_at) && m_valid && same_word(saddr, m_addr);
                if (w == hit_at) begin
                    if (k == K_LW || k == K_LL) m_data = ldata;
                    if (k == K_SC) m_data = 32'd1;
                end
                if (w == hit_at && k == K_LL) begin
                    m_valid = 1; m_addr = addr;
                end else if (snoop_hit) m_valid = 0;
            end
        end
        next_cycle();
        bus.dhit = 0; bus.ccinv = 0;
        exp_quiet(1'b1, addr, sdata);
        exp_load_vld = 1; exp_load = m_data;
        @(negedge CLK);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        nRST = 0;
        clear_inputs();
        #2;
        check1("rst_memW", bus.memW, 1'b1);
        check1("rst_dmemREN", bus.dmemREN, 1'b0);
        check1("rst_dmemWEN", bus.dmemWEN, 1'b0);
        check1("rst_datomic", bus.datomic, 1'b0);
        check32("rst_data", bus.memdmemload, 32'h0);
        #1 nRST = 1;
        exp_quiet(1'b1, '0, '0);
        chk_en = 1;

        idle(2, 1'b1, 1'b0, '0);                      // stray dhit in IDLE ignored
        run_op(K_LW, 32'h100, 32'h0, 3, 32'hDEADBEEF, 0, '0, 1'b0);
        check32("lw_stall", last_stall, 32'd4);
        check32("lw_data", last_load, 32'hDEADBEEF);
        run_op(K_SW, 32'h200, 32'h1234, 2, 32'h5555AAAA, 0, '0, 1'b1);
        check32("sw_stall", last_stall, 32'd3);
        check32("sw_keeps_data", last_load, 32'hDEADBEEF);
        run_op(K_LL, 32'h300, 32'h0, 1, 32'hCAFE0001, 0, '0, 1'b0);
        check32("ll_stall", last_stall, 32'd2);
        run_op(K_SC, 32'h300, 32'h77, 1, 32'hFFFFFFFF, 0, '0, 1'b0);
        check32("sc_ok_result", last_load, 32'h1);
        run_op(K_SC, 32'h300, 32'h77, 1, 32'h0, 0, '0, 1'b0);   // link consumed
        check32("sc_again_result", last_load, 32'h0);
        check32("sc_fail_stall", last_stall, 32'd1);

        run_op(K_LL, 32'h300, 32'h0, 1, 32'h11, 0, '0, 1'b0);
        idle(1, 1'b0, 1'b1, 32'h302);                 // snoop same word, other byte
        run_op(K_SC, 32'h300, 32'h9, 1, 32'h0, 0, '0, 1'b0);
        check32("sc_snooped_result", last_load, 32'h0);
        check32("sc_snooped_stall", last_stall, 32'd1);

        run_op(K_LL, 32'h300, 32'h0, 1, 32'h22, 0, '0, 1'b0);
        run_op(K_SW, 32'h300, 32'hABCD, 1, 32'h0, 0, '0, 1'b0);   // own store keeps link
        run_op(K_SC, 32'h300, 32'h1, 1, 32'h0, 0, '0, 1'b0);
        check32("sc_after_sw", last_load, 32'h1);

        run_op(K_LL, 32'h400, 32'h0, 2, 32'h44, 2, 32'h400, 1'b0); // LL vs snoop same cycle
        run_op(K_SC, 32'h400, 32'h2, 1, 32'h0, 0, '0, 1'b0);
        check32("sc_ll_snoop_race", last_load, 32'h1);

        run_op(K_LL, 32'h600, 32'h0, 1, 32'h66, 0, '0, 1'b0);
        idle(1, 1'b0, 1'b1, 32'h604);                 // neighbouring word, no effect
        run_op(K_SC, 32'h602, 32'h3, 2, 32'h0, 0, '0, 1'b0);
        check32("sc_same_word", last_load, 32'h1);

        run_op(K_LL, 32'h700, 32'h0, 1, 32'h77, 0, '0, 1'b0);
        run_op(K_SC, 32'h704, 32'h4, 1, 32'h0, 0, '0, 1'b0);
        check32("sc_other_word", last_load, 32'h0);

        run_op(K_LL, 32'h800, 32'h0, 1, 32'h88, 0, '0, 1'b0);
        run_op(K_SC, 32'h800, 32'h5, 3, 32'h0, 2, 32'h800, 1'b0); // snoop inside SC WAIT
        check32("sc_snoop_in_wait", last_load, 32'h1);

        // halted instruction in MEM makes no access
        for (int i = 0; i < 2; i++) begin
            next_cycle();
            set_op(K_LW, 32'hA00, 32'h0);
            bus.memcuHALT = 1;
            exp_quiet(1'b1, 32'hA00, 32'h0);
        end

        // reset in the middle of a load's WAIT drops the request and the link
        run_op(K_LL, 32'h500, 32'h0, 1, 32'h55, 0, '0, 1'b0);
        next_cycle();
        clear_inputs();
        set_op(K_LW, 32'h900, 32'h0);
        exp_quiet(1'b0, 32'h900, 32'h0);
        next_cycle();
        exp_quiet(1'b0, 32'h900, 32'h0);
        exp_ren = 1;
        @(negedge CLK);
        #1 chk_en = 0;
        nRST = 0;
        #1;
        check1("arst_dmemREN", bus.dmemREN, 1'b0);
        check1("arst_datomic", bus.datomic, 1'b0);
        clear_inputs();
        #1 nRST = 1;
        #1 check1("arst_memW_idle", bus.memW, 1'b1);
        m_valid = 0; m_data = '0; stall_cnt = 0;
        exp_quiet(1'b1, '0, '0);
        chk_en = 1;
        idle(1, 1'b0, 1'b0, '0);
        run_op(K_SC, 32'h500, 32'h6, 1, 32'h0, 0, '0, 1'b0);
        check32("sc_after_reset", last_load, 32'h0);
        check32("sc_after_reset_stall", last_stall, 32'd1);
        idle(2, 1'b0, 1'b0, '0);
        @(negedge CLK);
        #1;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
